// File: rtl/tc_to_signmag_serial.sv
// Bit-serial two's complement to sign-magnitude converter, LSB first.
// Negative words copy bits up to the first 1 and invert the rest.
module tc_to_signmag_serial #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [WIDTH-1:0] out_mag,
    output logic             out_minneg
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [CW-1:0]    count_q, count_d;
    logic             sign_q, sign_d;
    logic             seen_one_q, seen_one_d;
    logic             out_valid_q, out_valid_d;
    logic             out_sign_q, out_sign_d;
    logic             out_minneg_q, out_minneg_d;
    logic             bit_in;
    logic             res_bit;

    assign bit_in  = shift_q[0];
    assign res_bit = bit_in ^ (sign_q & seen_one_q);

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        mag_d        = mag_q;
        count_d      = count_q;
        sign_d       = sign_q;
        seen_one_d   = seen_one_q;
        out_valid_d  = out_valid_q;
        out_sign_d   = out_sign_q;
        out_minneg_d = out_minneg_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d    = in_data;
                    sign_d     = in_data[WIDTH-1];
                    count_d    = '0;
                    seen_one_d = 1'b0;
                    state_d    = CONV;
                end
            end
            CONV: begin
                seen_one_d = seen_one_q | bit_in;
                mag_d      = {res_bit, mag_q[WIDTH-1:1]};
                shift_d    = {1'b0, shift_q[WIDTH-1:1]};
                // Counter holds on the last bit so it never wraps for power-of-two widths.
                if (count_q == LAST_BIT) begin
                    state_d      = DONE;
                    out_valid_d  = 1'b1;
                    out_sign_d   = sign_q;
                    out_minneg_d = sign_q & res_bit;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            mag_q        <= '0;
            count_q      <= '0;
            sign_q       <= 1'b0;
            seen_one_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_sign_q   <= 1'b0;
            out_minneg_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            mag_q        <= mag_d;
            count_q      <= count_d;
            sign_q       <= sign_d;
            seen_one_q   <= seen_one_d;
            out_valid_q  <= out_valid_d;
            out_sign_q   <= out_sign_d;
            out_minneg_q <= out_minneg_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign out_sign   = out_sign_q;
    assign out_mag    = mag_q;
    assign out_minneg = out_minneg_q;

endmodule

// File: tb/tb_tc_to_signmag_serial.sv
// Scoreboard bench for tc_to_signmag_serial at WIDTH=32 and WIDTH=8.
module tb_tc_to_signmag_serial;

    typedef struct {
        logic        sign;
        logic [31:0] mag;
        logic        minneg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        out_ready;
    logic [31:0] in_data;
    logic        in_valid32, in_valid8;
    logic        in_ready32, in_ready8;
    logic        out_valid32, out_valid8;
    logic        out_sign32, out_sign8;
    logic        out_minneg32, out_minneg8;
    logic [31:0] out_mag32;
    logic [7:0]  out_mag8;

    logic        sel8;
    logic        iready_s, ovalid_s, osign_s, ominneg_s;
    logic [31:0] omag_s;
    int          width_s;

    int compared   = 0;
    int mismatched = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    tc_to_signmag_serial #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid32), .in_ready(in_ready32), .in_data(in_data),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_sign(out_sign32), .out_mag(out_mag32), .out_minneg(out_minneg32)
    );

    tc_to_signmag_serial #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data[7:0]),
        .out_valid(out_valid8), .out_ready(out_ready),
        .out_sign(out_sign8), .out_mag(out_mag8), .out_minneg(out_minneg8)
    );

    assign iready_s  = sel8 ? in_ready8   : in_ready32;
    assign ovalid_s  = sel8 ? out_valid8  : out_valid32;
    assign osign_s   = sel8 ? out_sign8   : out_sign32;
    assign ominneg_s = sel8 ? out_minneg8 : out_minneg32;
    assign omag_s    = sel8 ? {24'h0, out_mag8} : out_mag32;
    assign width_s   = sel8 ? 8 : 32;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain negation of the width-limited word, independent of the serial rule.
    function automatic exp_t refModel(input logic [31:0] x, input int w);
        exp_t e;
        logic [31:0] mask;
        logic [31:0] v;
        mask     = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        v        = x & mask;
        e.sign   = v[w-1];
        e.mag    = e.sign ? ((~v + 32'h1) & mask) : v;
        e.minneg = e.sign & e.mag[w-1];
        return e;
    endfunction

    task automatic applyStimulus(input logic [31:0] data);
        int n;
        n = 0;
        while (!iready_s && n < 200) begin
            @(posedge clk); #1; n++;
        end
        checkOutput("accept_ready", {63'h0, iready_s}, 64'h1);
        in_data = data;
        if (sel8) in_valid8 = 1'b1; else in_valid32 = 1'b1;
        @(posedge clk);
        sb.push_back(refModel(data, width_s));
        #1;
        in_valid8  = 1'b0;
        in_valid32 = 1'b0;
    endtask

    task automatic collectResult(input int hold, input int elapsed);
        exp_t e;
        int n;
        n = elapsed;
        while (!ovalid_s && n < 200) begin
            @(posedge clk); #1; n++;
        end
        checkOutput("latency", 64'(n), 64'(width_s));
        checkOutput("sb_depth", 64'(sb.size()), 64'h1);
        if (sb.size() != 0) e = sb.pop_front();
        checkOutput("sign", {63'h0, osign_s}, {63'h0, e.sign});
        checkOutput("mag", {32'h0, omag_s}, {32'h0, e.mag});
        checkOutput("minneg", {63'h0, ominneg_s}, {63'h0, e.minneg});
        checkOutput("done_in_ready", {63'h0, iready_s}, 64'h0);
        repeat (hold) begin
            @(posedge clk); #1;
            checkOutput("hold_valid", {63'h0, ovalid_s}, 64'h1);
            checkOutput("hold_mag", {32'h0, omag_s}, {32'h0, e.mag});
            checkOutput("hold_sign", {63'h0, osign_s}, {63'h0, e.sign});
            checkOutput("hold_in_ready", {63'h0, iready_s}, 64'h0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("post_valid", {63'h0, ovalid_s}, 64'h0);
        checkOutput("post_in_ready", {63'h0, iready_s}, 64'h1);
        checkOutput("post_mag_kept", {32'h0, omag_s}, {32'h0, e.mag});
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_valid"}, {63'h0, ovalid_s}, 64'h0);
        checkOutput({tag, "_sign"}, {63'h0, osign_s}, 64'h0);
        checkOutput({tag, "_mag"}, {32'h0, omag_s}, 64'h0);
        checkOutput({tag, "_minneg"}, {63'h0, ominneg_s}, 64'h0);
        checkOutput({tag, "_in_ready"}, {63'h0, iready_s}, 64'h1);
    endtask

    task automatic convertWord(input logic [31:0] data);
        applyStimulus(data);
        collectResult(0, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] r;
        rst        = 1'b1;
        in_valid32 = 1'b0;
        in_valid8  = 1'b0;
        out_ready  = 1'b0;
        in_data    = '0;
        sel8       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkResetState("reset32");
        sel8 = 1'b1; #0;
        #1;
        checkResetState("reset8");
        sel8 = 1'b0;
        #1;

        $display("[TB] WIDTH=32 directed words");
        convertWord(32'h0000_0005);
        convertWord(32'hFFFF_FFFB);
        convertWord(32'hFFFF_FFFF);
        convertWord(32'h8000_0000);
        convertWord(32'h0000_0000);
        convertWord(32'h0000_0001);

        $display("[TB] WIDTH=32 output hold under backpressure");
        applyStimulus(32'hFFFF_1234);
        collectResult(10, 0);

        $display("[TB] WIDTH=32 in_valid while busy");
        applyStimulus(32'h1234_5678);
        for (int i = 0; i < 6; i++) begin
            in_valid32 = 1'b1;
            in_data    = $urandom;
            @(posedge clk); #1;
            checkOutput("busy_in_ready", {63'h0, iready_s}, 64'h0);
        end
        in_valid32 = 1'b0;
        collectResult(0, 6);
        convertWord(32'hC000_0001);

        $display("[TB] WIDTH=32 reset during conversion");
        applyStimulus(32'hDEAD_BEEF);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb.pop_back());
        checkResetState("midreset");
        convertWord(32'h7FFF_FFFF);

        for (int i = 0; i < 5; i++) begin
            r = $urandom;
            convertWord(r);
        end

        $display("[TB] WIDTH=8 words");
        sel8 = 1'b1;
        #1;
        convertWord(32'h0000_0080);
        convertWord(32'h0000_00F0);
        convertWord(32'h0000_007F);
        convertWord(32'h0000_0000);
        applyStimulus(32'h0000_00FF);
        collectResult(3, 0);
        for (int i = 0; i < 5; i++) begin
            r = $urandom;
            convertWord(r & 32'hFF);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
